// File: rtl/spike_aer_encoder.sv
// Converts a block-major spike raster stream into address-event packets {block, neuron, value}.
// Define AER_TIMESTAMP_EN to prepend a 16-bit per-frame cycle timestamp to every event.
module spike_aer_encoder #(
    parameter int T  = 8,
    parameter int N  = 16,
    parameter int NN = 16,
    parameter int NU = 8,
    localparam int TA = $clog2(T),
    localparam int NA = $clog2(N),
    localparam int CW = $clog2(T*N+1),
`ifdef AER_TIMESTAMP_EN
    localparam int DW = TA+NA+NU+16
`else
    localparam int DW = TA+NA+NU
`endif
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [NN-1:0] s_axis_tdata,
    input  logic [NU-1:0] s_axis_tuser,
    input  logic          s_axis_tlast,
    output logic          m_aer_tvalid,
    input  logic          m_aer_tready,
    output logic [DW-1:0] m_aer_tdata,
    output logic          m_aer_tlast,
    output logic          frame_done,
    output logic [CW-1:0] spike_count,
    output logic          frame_error
);

    typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [TA-1:0] BLK_MAX = TA'(T-1);
    localparam logic [NA-1:0] NRN_MAX = NA'(N-1);
    localparam logic [CW-1:0] CNT_MAX = CW'(T*N);

    state_t        state_r;
    logic [TA-1:0] blk_r;
    logic [NA-1:0] nrn_r;
    logic          pend_valid_r;
    logic [DW-1:0] pend_data_r;
    logic          out_valid_r;
    logic          out_last_r;
    logic [DW-1:0] out_data_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] frame_cnt_r;
    logic [CW-1:0] spike_count_r;
    logic          frame_done_r;
    logic          frame_error_r;

    logic          out_free_s;
    logic          drain_s;
    logic          accept_s;
    logic          spk_s;
    logic          last_idx_s;
    logic          eof_s;
    logic [DW-1:0] new_ev_s;
    logic          unused_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic inc);
        logic [CW-1:0] r;
        if (inc && (c != CNT_MAX)) r = c + CW'(1);
        else                       r = c;
        return r;
    endfunction

    assign drain_s       = out_valid_r & m_aer_tready;
    assign out_free_s    = ~out_valid_r | m_aer_tready;
    assign s_axis_tready = aresetn & (state_r == RUN) & out_free_s;
    assign accept_s      = s_axis_tvalid & s_axis_tready;
    assign spk_s         = (s_axis_tuser != {NU{1'b0}});
    assign last_idx_s    = (blk_r == BLK_MAX) & (nrn_r == NRN_MAX);
    assign eof_s         = accept_s & (s_axis_tlast | last_idx_s);
    assign unused_s      = ^s_axis_tdata;

`ifdef AER_TIMESTAMP_EN
    logic [15:0] ts_r;
    logic [15:0] ts_now_s;
    logic        first_s;

    assign first_s  = (blk_r == {TA{1'b0}}) & (nrn_r == {NA{1'b0}});
    assign ts_now_s = first_s ? 16'd0 : ts_r;
    assign new_ev_s = {ts_now_s, blk_r, nrn_r, s_axis_tuser};

    // Free-running stamp, restarted by the first accepted beat of each frame
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ts_r <= 16'd0;
        end else if (accept_s && first_s) begin
            ts_r <= 16'd1;
        end else begin
            ts_r <= ts_r + 16'd1;
        end
    end
`else
    assign new_ev_s = {blk_r, nrn_r, s_axis_tuser};
`endif

    // Index counters, one-deep pending event, output register and frame bookkeeping
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r       <= RUN;
            blk_r         <= {TA{1'b0}};
            nrn_r         <= {NA{1'b0}};
            pend_valid_r  <= 1'b0;
            pend_data_r   <= {DW{1'b0}};
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_data_r    <= {DW{1'b0}};
            cnt_r         <= {CW{1'b0}};
            frame_cnt_r   <= {CW{1'b0}};
            spike_count_r <= {CW{1'b0}};
            frame_done_r  <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (drain_s) begin
                out_valid_r <= 1'b0;
                if (out_last_r) begin
                    frame_done_r  <= 1'b1;
                    spike_count_r <= frame_cnt_r;
                end
            end
            if (accept_s) begin
                // early tlast or missing tlast at the final index
                if (s_axis_tlast ^ last_idx_s) frame_error_r <= 1'b1;
                if (eof_s) begin
                    blk_r <= {TA{1'b0}};
                    nrn_r <= {NA{1'b0}};
                end else if (nrn_r == NRN_MAX) begin
                    nrn_r <= {NA{1'b0}};
                    blk_r <= blk_r + TA'(1);
                end else begin
                    nrn_r <= nrn_r + NA'(1);
                end
            end
            case (state_r)
                RUN: begin
                    if (eof_s) begin
                        cnt_r       <= {CW{1'b0}};
                        frame_cnt_r <= sat_inc(cnt_r, spk_s);
                        if (spk_s && pend_valid_r) begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= pend_data_r;
                            out_last_r  <= 1'b0;
                            pend_data_r <= new_ev_s;
                            state_r     <= FLUSH;
                        end else if (spk_s) begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= new_ev_s;
                            out_last_r  <= 1'b1;
                        end else if (pend_valid_r) begin
                            out_valid_r  <= 1'b1;
                            out_data_r   <= pend_data_r;
                            out_last_r   <= 1'b1;
                            pend_valid_r <= 1'b0;
                        end else begin
                            frame_done_r  <= 1'b1;
                            spike_count_r <= {CW{1'b0}};
                        end
                    end else if (accept_s && spk_s) begin
                        cnt_r <= sat_inc(cnt_r, 1'b1);
                        if (pend_valid_r) begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= pend_data_r;
                            out_last_r  <= 1'b0;
                        end
                        pend_data_r  <= new_ev_s;
                        pend_valid_r <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (out_free_s) begin
                        out_valid_r  <= 1'b1;
                        out_data_r   <= pend_data_r;
                        out_last_r   <= 1'b1;
                        pend_valid_r <= 1'b0;
                        state_r      <= RUN;
                    end
                end
                default: state_r <= RUN;
            endcase
        end
    end

    assign m_aer_tvalid = out_valid_r;
    assign m_aer_tdata  = out_data_r;
    assign m_aer_tlast  = out_last_r;
    assign frame_done   = frame_done_r;
    assign spike_count  = spike_count_r;
    assign frame_error  = frame_error_r;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Randomized bench for spike_aer_encoder: a frame-level model predicts the event stream,
// per-frame spike counts and the sticky framing error.
module tb_spike_aer_encoder;
    localparam int T  = 8;
    localparam int N  = 16;
    localparam int NN = 16;
    localparam int NU = 8;
    localparam int CW = 8;
    localparam int DW = 15;

    logic          aclk;
    logic          aresetn;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [NN-1:0] s_axis_tdata;
    logic [NU-1:0] s_axis_tuser;
    logic          s_axis_tlast;
    logic          m_aer_tvalid;
    logic          m_aer_tready;
    logic [DW-1:0] m_aer_tdata;
    logic          m_aer_tlast;
    logic          frame_done;
    logic [CW-1:0] spike_count;
    logic          frame_error;

    int          checks;
    int          failures;
    logic [15:0] exp_q[$];
    int          cnt_q[$];
    bit          exp_err;
    bit          rdy_mode;
    int          done_cnt;
    int          frames_exp;
    logic [7:0]  fv[128];
    logic        hold_v;
    logic [15:0] hold_d;

    spike_aer_encoder #(.T(T), .N(N), .NN(NN), .NU(NU)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .m_aer_tvalid(m_aer_tvalid), .m_aer_tready(m_aer_tready),
        .m_aer_tdata(m_aer_tdata), .m_aer_tlast(m_aer_tlast),
        .frame_done(frame_done), .spike_count(spike_count), .frame_error(frame_error)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic clear_fv();
        for (int i = 0; i < 128; i++) fv[i] = 8'd0;
    endtask

    // Build expectations from the frame contents, then drive its beats with AXI-legal valid
    task automatic send_frame(input int len, input bit tl_en, input int vprob, input bit model);
        int last_i;
        int nsp;
        last_i = -1;
        nsp    = 0;
        for (int i = 0; i < len; i++) if (fv[i] != 8'd0) last_i = i;
        if (model) begin
            for (int i = 0; i < len; i++) begin
                if (fv[i] != 8'd0) begin
                    exp_q.push_back({(i == last_i), 3'(i / N), 4'(i % N), fv[i]});
                    nsp++;
                end
            end
            cnt_q.push_back(nsp);
            frames_exp++;
            if (len != T*N || !tl_en) exp_err = 1'b1;
        end
        for (int i = 0; i < len; i++) begin
            int w;
            w = 0;
            @(negedge aclk);
            s_axis_tuser  = fv[i];
            s_axis_tdata  = 16'($urandom);
            s_axis_tlast  = tl_en && (i == len - 1);
            s_axis_tvalid = 1'b0;
            forever begin
                if (!s_axis_tvalid) s_axis_tvalid = ($urandom_range(0, 99) < vprob);
                #2;
                if (s_axis_tvalid && s_axis_tready) break;
                w++;
                if (w > 1000) begin
                    check_value("beat_timeout", 32'd0, 32'd1);
                    s_axis_tvalid = 1'b0;
                    return;
                end
                @(negedge aclk);
            end
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || cnt_q.size() != 0) && w < 3000) begin
            @(negedge aclk);
            w++;
        end
        if (w >= 3000) check_value("drain_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge aclk);
    endtask

    initial begin
        m_aer_tready = 1'b1;
        forever begin
            @(negedge aclk);
            m_aer_tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard: event order/content, stall stability, frame_done and spike_count
    initial begin
        hold_v = 1'b0;
        hold_d = 16'd0;
        forever begin
            @(negedge aclk);
            #2;
            if (!aresetn) begin
                hold_v = 1'b0;
                continue;
            end
            if (hold_v) begin
                check_value("stall_valid", {31'd0, m_aer_tvalid}, 32'd1);
                check_value("stall_data", {16'd0, m_aer_tlast, m_aer_tdata}, {16'd0, hold_d});
            end
            hold_v = m_aer_tvalid && !m_aer_tready;
            hold_d = {m_aer_tlast, m_aer_tdata};
            if (m_aer_tvalid && m_aer_tready) begin
                if (exp_q.size() == 0) check_value("extra_event", {16'd0, m_aer_tlast, m_aer_tdata}, 32'hFFFF_FFFF);
                else check_value("event", {16'd0, m_aer_tlast, m_aer_tdata}, {16'd0, exp_q.pop_front()});
            end
            if (frame_done) begin
                done_cnt++;
                if (cnt_q.size() == 0) check_value("extra_done", 32'd1, 32'd0);
                else check_value("spike_count", {24'd0, spike_count}, 32'(cnt_q.pop_front()));
            end
        end
    end

    initial begin
        checks = 0; failures = 0; exp_err = 1'b0; rdy_mode = 1'b0;
        done_cnt = 0; frames_exp = 0;
        aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = 16'd0;
        s_axis_tuser = 8'd0; s_axis_tlast = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        check_value("rst_tvalid", {31'd0, m_aer_tvalid}, 32'd0);
        check_value("rst_tdata", {17'd0, m_aer_tdata}, 32'd0);
        check_value("rst_done", {31'd0, frame_done}, 32'd0);
        check_value("rst_err", {31'd0, frame_error}, 32'd0);
        check_value("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        clear_fv(); fv[37] = 8'd3;
        send_frame(128, 1'b1, 100, 1'b1);
        #2 check_value("t1_latency", {31'd0, m_aer_tvalid}, 32'd1);
        wait_drain();
        check_value("t1_count", {24'd0, spike_count}, 32'd1);

        clear_fv();
        send_frame(128, 1'b1, 100, 1'b1);
        #2 check_value("t2_done", {31'd0, frame_done}, 32'd1);
        check_value("t2_novalid", {31'd0, m_aer_tvalid}, 32'd0);
        wait_drain();
        check_value("t2_count", {24'd0, spike_count}, 32'd0);

        clear_fv(); fv[0] = 8'd1; fv[127] = 8'd9;
        send_frame(128, 1'b1, 100, 1'b1);
        #2 check_value("t3_flush_ready", {31'd0, s_axis_tready}, 32'd0);
        @(negedge aclk);
        #2 check_value("t3_run_ready", {31'd0, s_axis_tready}, 32'd1);
        wait_drain();
        check_value("t3_err", {31'd0, frame_error}, {31'd0, exp_err});

        rdy_mode = 1'b1;
        for (int f = 0; f < 4; f++) begin
            clear_fv();
            for (int k = 0; k < 10; k++) begin
                int p;
                p = $urandom_range(0, 127);
                while (fv[p] != 8'd0) p = $urandom_range(0, 127);
                fv[p] = 8'($urandom_range(1, 255));
            end
            send_frame(128, 1'b1, 70, 1'b1);
        end
        wait_drain();
        rdy_mode = 1'b0;
        check_value("t4_err", {31'd0, frame_error}, {31'd0, exp_err});

        clear_fv(); fv[10] = 8'($urandom_range(1, 255)); fv[40] = 8'($urandom_range(1, 255));
        send_frame(50, 1'b1, 100, 1'b1);
        clear_fv(); fv[0] = 8'd7; fv[64] = 8'd2;
        send_frame(128, 1'b1, 80, 1'b1);
        wait_drain();
        check_value("t5_early_err", {31'd0, frame_error}, {31'd0, exp_err});
        clear_fv(); fv[5] = 8'd4;
        send_frame(128, 1'b0, 100, 1'b1);
        wait_drain();
        check_value("t5_sticky_err", {31'd0, frame_error}, {31'd0, exp_err});

        clear_fv(); fv[50] = 8'd5;
        send_frame(60, 1'b0, 100, 1'b0);
        #3 aresetn = 1'b0;
        #1;
        check_value("t6_tvalid", {31'd0, m_aer_tvalid}, 32'd0);
        check_value("t6_count", {24'd0, spike_count}, 32'd0);
        check_value("t6_err", {31'd0, frame_error}, 32'd0);
        check_value("t6_tready", {31'd0, s_axis_tready}, 32'd0);
        exp_q.delete(); cnt_q.delete(); exp_err = 1'b0;
        repeat (2) @(negedge aclk);
        #3 aresetn = 1'b1;
        clear_fv(); fv[0] = 8'd4; fv[37] = 8'd3;
        send_frame(128, 1'b1, 100, 1'b1);
        wait_drain();
        check_value("t6_post_count", {24'd0, spike_count}, 32'd2);
        check_value("t6_post_err", {31'd0, frame_error}, 32'd0);

        check_value("done_total", 32'(done_cnt), 32'(frames_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
